// File: rtl/xor_event_counter.sv
// Windowed rising-edge counter for the two HelloVlog parity flags.
// Counts per-channel edges over WINDOW cycles, saturates, and hands results out via valid/ready.
module xor_event_counter #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             A_xor_in,
    input  logic             B_xor_in,
    input  logic             Enable,
    input  logic             Clear,
    input  logic             Rd_ready,
    output logic             Rd_valid,
    output logic [CNT_W-1:0] A_count_out,
    output logic [CNT_W-1:0] B_count_out,
    output logic [1:0]       Ovf_out,
    output logic             Busy
);

    localparam int unsigned       WC_W    = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               a_prev, b_prev;
    logic [CNT_W-1:0]   a_cnt, a_cnt_nxt;
    logic [CNT_W-1:0]   b_cnt, b_cnt_nxt;
    logic [1:0]         ovf, ovf_nxt;
    logic [WC_W-1:0]    wcnt, wcnt_nxt;
    logic               rd_valid_nxt;
    logic [CNT_W-1:0]   a_out_nxt, b_out_nxt;
    logic [1:0]         ovf_out_nxt;
    logic               a_rise, b_rise;

    assign a_rise = A_xor_in & ~a_prev;
    assign b_rise = B_xor_in & ~b_prev;
    assign Busy   = (state == COUNT);

    // Prev registers track the inputs in every state; Clear leaves them alone
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            a_prev      <= 1'b0;
            b_prev      <= 1'b0;
            a_cnt       <= '0;
            b_cnt       <= '0;
            ovf         <= 2'b00;
            wcnt        <= '0;
            Rd_valid    <= 1'b0;
            A_count_out <= '0;
            B_count_out <= '0;
            Ovf_out     <= 2'b00;
        end else begin
            state       <= state_nxt;
            a_prev      <= A_xor_in;
            b_prev      <= B_xor_in;
            a_cnt       <= a_cnt_nxt;
            b_cnt       <= b_cnt_nxt;
            ovf         <= ovf_nxt;
            wcnt        <= wcnt_nxt;
            Rd_valid    <= rd_valid_nxt;
            A_count_out <= a_out_nxt;
            B_count_out <= b_out_nxt;
            Ovf_out     <= ovf_out_nxt;
        end
    end

    // Next-state and datapath; Clear overrides everything at the end
    always_comb begin
        state_nxt    = state;
        a_cnt_nxt    = a_cnt;
        b_cnt_nxt    = b_cnt;
        ovf_nxt      = ovf;
        wcnt_nxt     = wcnt;
        rd_valid_nxt = Rd_valid;
        a_out_nxt    = A_count_out;
        b_out_nxt    = B_count_out;
        ovf_out_nxt  = Ovf_out;

        case (state)
            IDLE: begin
                a_cnt_nxt = '0;
                b_cnt_nxt = '0;
                ovf_nxt   = 2'b00;
                wcnt_nxt  = '0;
                if (Enable) begin
                    state_nxt = COUNT;
                end
            end

            COUNT: begin
                wcnt_nxt = wcnt + WC_W'(1);
                if (a_rise) begin
                    if (a_cnt == CNT_MAX) ovf_nxt[0] = 1'b1;
                    else                  a_cnt_nxt  = a_cnt + CNT_W'(1);
                end
                if (b_rise) begin
                    if (b_cnt == CNT_MAX) ovf_nxt[1] = 1'b1;
                    else                  b_cnt_nxt  = b_cnt + CNT_W'(1);
                end
                if (!Enable) begin
                    // Abort: partial counts are discarded
                    state_nxt = IDLE;
                    a_cnt_nxt = '0;
                    b_cnt_nxt = '0;
                    ovf_nxt   = 2'b00;
                    wcnt_nxt  = '0;
                end else if (wcnt == WC_LAST) begin
                    state_nxt    = HOLD;
                    rd_valid_nxt = 1'b1;
                    a_out_nxt    = a_cnt_nxt;
                    b_out_nxt    = b_cnt_nxt;
                    ovf_out_nxt  = ovf_nxt;
                end
            end

            HOLD: begin
                if (Rd_valid && Rd_ready) begin
                    rd_valid_nxt = 1'b0;
                    a_cnt_nxt    = '0;
                    b_cnt_nxt    = '0;
                    ovf_nxt      = 2'b00;
                    wcnt_nxt     = '0;
                    state_nxt    = Enable ? COUNT : IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (Clear) begin
            state_nxt    = IDLE;
            a_cnt_nxt    = '0;
            b_cnt_nxt    = '0;
            ovf_nxt      = 2'b00;
            wcnt_nxt     = '0;
            rd_valid_nxt = 1'b0;
            a_out_nxt    = '0;
            b_out_nxt    = '0;
            ovf_out_nxt  = 2'b00;
        end
    end

endmodule

// File: tb/tb_xor_event_counter.sv
// Directed bench for xor_event_counter: a default instance and a small saturating instance.
module tb_xor_event_counter;

    logic       Clock;
    logic       Reset_n;
    logic       A_in, B_in, en, en_s, clr, rdy;

    logic       rv, busy;
    logic [7:0] ac, bc;
    logic [1:0] ov;

    logic       rv_s, busy_s;
    logic [2:0] ac_s, bc_s;
    logic [1:0] ov_s;

    int n_cmp = 0;
    int n_bad = 0;

    xor_event_counter dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .A_xor_in    (A_in),
        .B_xor_in    (B_in),
        .Enable      (en),
        .Clear       (clr),
        .Rd_ready    (rdy),
        .Rd_valid    (rv),
        .A_count_out (ac),
        .B_count_out (bc),
        .Ovf_out     (ov),
        .Busy        (busy)
    );

    xor_event_counter #(.CNT_W(3), .WINDOW(20)) dut_s (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .A_xor_in    (A_in),
        .B_xor_in    (B_in),
        .Enable      (en_s),
        .Clear       (clr),
        .Rd_ready    (rdy),
        .Rd_valid    (rv_s),
        .A_count_out (ac_s),
        .B_count_out (bc_s),
        .Ovf_out     (ov_s),
        .Busy        (busy_s)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        A_in = 0; B_in = 0; en = 0; en_s = 0; clr = 0; rdy = 0;
        step();
        step();
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_dut: got %h want %h", {rv, ac, bc, ov, busy}, 20'h0);
        end
        n_cmp++;
        if ({rv_s, ac_s, bc_s, ov_s, busy_s} !== 10'h0) begin
            n_bad++;
            $display("FAIL reset_sat: got %h want %h", {rv_s, ac_s, bc_s, ov_s, busy_s}, 10'h0);
        end
        @(posedge Clock);
        #2 Reset_n = 1'b1;
        step();
        n_cmp++;
        if ({rv, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", {rv, busy}, 2'b00);
        end
    endtask

    task automatic test_basic();
        en = 0; rdy = 1; A_in = 0; B_in = 1;
        step();
        step();
        en = 1;
        for (int k = 0; k <= 16; k++) begin
            A_in = k[0];
            step();
            if (k == 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL basic_busy: got %b want 1", busy);
                end
            end
            if (k == 15) begin
                n_cmp++;
                if (rv !== 1'b0) begin
                    n_bad++;
                    $display("FAIL basic_early_valid: got %b want 0", rv);
                end
            end
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd8, 8'd0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd8, 8'd0, 2'b00, 1'b0});
        end
        en = 0;
        step();
        n_cmp++;
        if ({rv, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_handshake: got %b want %b", {rv, busy}, 2'b00);
        end
    endtask

    task automatic test_saturation();
        A_in = 0; B_in = 0; rdy = 0; clr = 1;
        step();
        clr = 0; en_s = 1;
        for (int k = 0; k <= 20; k++) begin
            A_in = k[0];
            B_in = (k == 2 || k == 5 || k == 8);
            step();
        end
        n_cmp++;
        if ({rv_s, ac_s, bc_s, ov_s, busy_s} !== {1'b1, 3'd7, 3'd3, 2'b01, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_result: got %h want %h", {rv_s, ac_s, bc_s, ov_s, busy_s},
                     {1'b1, 3'd7, 3'd3, 2'b01, 1'b0});
        end
        en_s = 0; rdy = 1; A_in = 0; B_in = 0;
        step();
        n_cmp++;
        if (rv_s !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_handshake: got %b want 0", rv_s);
        end
    endtask

    task automatic test_backpressure();
        rdy = 0; en = 1; A_in = 0; B_in = 0;
        for (int k = 0; k <= 16; k++) begin
            A_in = (k == 3);
            B_in = (k == 7 || k == 10);
            step();
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd1, 8'd2, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_result: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd1, 8'd2, 2'b00, 1'b0});
        end
        for (int j = 0; j < 5; j++) begin
            A_in = ~j[0];
            B_in = j[0];
            step();
            n_cmp++;
            if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd1, 8'd2, 2'b00, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got %h want %h", j, {rv, ac, bc, ov, busy},
                         {1'b1, 8'd1, 8'd2, 2'b00, 1'b0});
            end
        end
        A_in = 0; B_in = 0; rdy = 1;
        step();
        n_cmp++;
        if ({rv, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_handshake: got %b want %b", {rv, busy}, 2'b01);
        end
        rdy = 0;
        for (int m = 1; m <= 16; m++) begin
            A_in = (m == 2);
            step();
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd1, 8'd0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_next_window: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd1, 8'd0, 2'b00, 1'b0});
        end
        en = 0; rdy = 1;
        step();
    endtask

    task automatic test_abort();
        rdy = 0; en = 1; A_in = 0; B_in = 0;
        for (int k = 0; k <= 8; k++) begin
            A_in = (k == 2 || k == 4);
            step();
        end
        A_in = 0; en = 0;
        step();
        n_cmp++;
        if ({rv, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_idle: got %b want %b", {rv, busy}, 2'b00);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if ({rv, ac, bc, busy} !== {1'b0, 8'd1, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_no_result: got %h want %h", {rv, ac, bc, busy},
                     {1'b0, 8'd1, 8'd0, 1'b0});
        end
        en = 1;
        for (int k = 0; k <= 16; k++) begin
            B_in = (k == 3);
            step();
            if (k == 15) begin
                n_cmp++;
                if (rv !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_next_early: got %b want 0", rv);
                end
            end
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd0, 8'd1, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_next_window: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd0, 8'd1, 2'b00, 1'b0});
        end
        en = 0; rdy = 1; B_in = 0;
        step();
    endtask

    task automatic test_clear_vs_handshake();
        rdy = 0; en = 1; A_in = 0; B_in = 0;
        for (int k = 0; k <= 16; k++) begin
            A_in = (k == 5);
            step();
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd1, 8'd0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL clr_pre: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd1, 8'd0, 2'b00, 1'b0});
        end
        clr = 1; rdy = 1;
        step();
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== 20'h0) begin
            n_bad++;
            $display("FAIL clr_wins: got %h want %h", {rv, ac, bc, ov, busy}, 20'h0);
        end
        clr = 0; en = 0;
        step();
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== 20'h0) begin
            n_bad++;
            $display("FAIL clr_idle: got %h want %h", {rv, ac, bc, ov, busy}, 20'h0);
        end
    endtask

    task automatic test_reset_mid_window();
        rdy = 1; en = 1; A_in = 0; B_in = 0;
        for (int k = 0; k <= 16; k++) begin
            A_in = (k == 1 || k == 3);
            step();
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd2, 8'd0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_pre: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd2, 8'd0, 2'b00, 1'b0});
        end
        A_in = 0;
        step();
        n_cmp++;
        if ({rv, ac, busy} !== {1'b0, 8'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_second_window: got %h want %h", {rv, ac, busy}, {1'b0, 8'd2, 1'b1});
        end
        for (int m = 1; m <= 4; m++) begin
            A_in = (m == 2);
            step();
        end
        #3 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== 20'h0) begin
            n_bad++;
            $display("FAIL rst_async: got %h want %h", {rv, ac, bc, ov, busy}, 20'h0);
        end
        en = 0; A_in = 0;
        @(posedge Clock);
        #2 Reset_n = 1'b1;
        step();
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== 20'h0) begin
            n_bad++;
            $display("FAIL rst_no_result: got %h want %h", {rv, ac, bc, ov, busy}, 20'h0);
        end
        en = 1;
        for (int k = 0; k <= 16; k++) begin
            B_in = (k == 4);
            step();
        end
        n_cmp++;
        if ({rv, ac, bc, ov, busy} !== {1'b1, 8'd0, 8'd1, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_after: got %h want %h", {rv, ac, bc, ov, busy},
                     {1'b1, 8'd0, 8'd1, 2'b00, 1'b0});
        end
        en = 0; B_in = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_abort();
        test_clear_vs_handshake();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
